// File: rtl/uart_rx_fifo_mmio_pkg.sv
// uart_rx_fifo_mmio_pkg
//   Shared definitions for the UART receive FIFO peripheral:
//   - register indices, selected by mem_addr[3:2]
//   - STATUS and CTRL bit positions
//   - the DATA valid bit position
//   - a helper that packs a DATA read word
//   No ports; imported by uart_rx_fifo_mmio and sync_fifo8.

package uart_rx_fifo_mmio_pkg;

  // Register indices (mem_addr[3:2]); index 3 is reserved and reads zero.
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions; the FIFO count occupies bits [STAT_COUNT_LSB +: AW+1].
  localparam int unsigned STAT_NOT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT      = 1;
  localparam int unsigned STAT_OVERRUN_BIT   = 2;
  localparam int unsigned STAT_IRQ_EN_BIT    = 3;
  localparam int unsigned STAT_COUNT_LSB     = 8;

  // CTRL bit positions; flush and clr_ovr are self-clearing commands.
  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_CLR_OVR_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

  // DATA read word: {23'b0, valid, byte}.
  localparam int unsigned DATA_VALID_BIT = 8;

  // Packs a DATA read word; an empty FIFO reads as all zeros.
  function automatic logic [31:0] data_word(input logic valid, input logic [7:0] rx_b);
    logic [31:0] w;
    w = 32'd0;
    if (valid) begin
      w[7:0]           = rx_b;
      w[DATA_VALID_BIT] = 1'b1;
    end else begin
      w = 32'd0;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mmio_sync_fifo8.sv
// sync_fifo8
//   Byte-wide synchronous FIFO with flush.
//   Ports:
//     clk, reset    : clock and synchronous active-high reset
//     flush         : empties the FIFO; wins over a simultaneous push
//     push, din     : write request and byte
//     pop           : read request (ignored when empty)
//     dout          : head byte, read combinationally from the array
//     count         : occupancy 0..DEPTH (AW+1 bits)
//     full, empty   : occupancy flags
//   A push while full is dropped unless an effective pop happens in the
//   same cycle, in which case both occur and count stays at DEPTH.

module sync_fifo8
  import uart_rx_fifo_mmio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE_C  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO_C = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop_s;
  logic          do_push_s;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == CNT_ZERO_C);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop needs data; a push needs room, which an accepted pop provides.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer and occupancy next state; flush returns everything to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO_C;
      rd_ptr_d = PTR_ZERO_C;
      count_d  = CNT_ZERO_C;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage next state: the tail slot takes din on an accepted, unflushed push.
  always_comb begin
    mem_d = mem_q;
    if (do_push_s & ~flush) begin
      mem_d[wr_ptr_q] = din;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO_C;
      rd_ptr_q <= PTR_ZERO_C;
      count_q  <= CNT_ZERO_C;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_mmio.sv
// uart_rx_fifo_mmio
//   IO-page bus responder that buffers UART receive bytes in a FIFO.
//   Ports:
//     clk, reset        : clock and synchronous active-high reset
//     sel               : IO-page select decoded by the SoC
//     mem_addr[3:0]     : byte address; register index = mem_addr[3:2]
//     mem_rstrb         : read strobe
//     mem_wdata[31:0]   : write data (only CTRL bits [2:0] are meaningful)
//     mem_wmask[3:0]    : byte write mask; CTRL needs bit 0
//     mem_rdata[31:0]   : registered read data, held between selected reads
//     rx_dv, rx_byte    : one-cycle byte-valid pulse and byte from the receiver
//     irq               : irq_en & (not_empty | overrun), from registered state
//   Registers: 0 DATA (read pops), 1 STATUS, 2 CTRL, 3 reserved.

module uart_rx_fifo_mmio
  import uart_rx_fifo_mmio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        irq
);

  logic [1:0]  reg_idx_s;
  logic        rd_req_s;
  logic        pop_req_s;
  logic        ctrl_wr_s;
  logic        flush_s;
  logic        clr_ovr_s;
  logic        ovr_set_s;
  logic [7:0]  fifo_head_s;
  logic [AW:0] fifo_count_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [31:0] status_word_s;
  logic [31:0] ctrl_word_s;
  logic        unused_bus_bits_s;

  logic [31:0] rdata_q, rdata_d;
  logic        overrun_q, overrun_d;
  logic        irq_en_q, irq_en_d;

  assign reg_idx_s = mem_addr[3:2];
  assign rd_req_s  = sel & mem_rstrb;
  // The FIFO itself ignores a pop when empty, so no not_empty term is needed here.
  assign pop_req_s = rd_req_s & (reg_idx_s == REG_DATA);
  assign ctrl_wr_s = sel & mem_wmask[0] & (reg_idx_s == REG_CTRL);
  assign flush_s   = ctrl_wr_s & mem_wdata[CTRL_FLUSH_BIT];
  assign clr_ovr_s = ctrl_wr_s & mem_wdata[CTRL_CLR_OVR_BIT];

  // A byte is lost only when full with no pop to make room; a flush discards
  // the byte deliberately and does not count as an overrun.
  assign ovr_set_s = rx_dv & fifo_full_s & ~pop_req_s & ~flush_s;

  assign unused_bus_bits_s = ^{mem_addr[1:0], mem_wmask[3:1], mem_wdata[31:3]};

  sync_fifo8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_s),
    .push  (rx_dv),
    .din   (rx_byte),
    .pop   (pop_req_s),
    .dout  (fifo_head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // STATUS and CTRL read words assembled from current state.
  always_comb begin
    status_word_s = 32'd0;
    status_word_s[STAT_NOT_EMPTY_BIT]        = ~fifo_empty_s;
    status_word_s[STAT_FULL_BIT]             = fifo_full_s;
    status_word_s[STAT_OVERRUN_BIT]          = overrun_q;
    status_word_s[STAT_IRQ_EN_BIT]           = irq_en_q;
    status_word_s[STAT_COUNT_LSB +: AW+1]    = fifo_count_s;
    ctrl_word_s = 32'd0;
    ctrl_word_s[CTRL_IRQ_EN_BIT]             = irq_en_q;
  end

  // Read mux; the value is captured only on a selected read and held otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_req_s) begin
      case (reg_idx_s)
        REG_DATA:   rdata_d = data_word(~fifo_empty_s, fifo_head_s);
        REG_STATUS: rdata_d = status_word_s;
        REG_CTRL:   rdata_d = ctrl_word_s;
        default:    rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Sticky overrun and stored irq_en; a new drop outranks a same-cycle clear
  // so a lost byte is never hidden from software.
  always_comb begin
    overrun_d = overrun_q;
    irq_en_d  = irq_en_q;
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clr_ovr_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (ctrl_wr_s) begin
      irq_en_d = mem_wdata[CTRL_IRQ_EN_BIT];
    end else begin
      irq_en_d = irq_en_q;
    end
  end

  // Bus-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= 32'd0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign irq       = irq_en_q & (~fifo_empty_s | overrun_q);

endmodule

// File: tb/tb_uart_rx_fifo_mmio.sv
// tb_uart_rx_fifo_mmio
//   Directed steps followed by a randomized phase. A queue-based model of the
//   peripheral predicts mem_rdata and irq after every clock; directed steps
//   also compare selected reads with literal values.

module tb_uart_rx_fifo_mmio;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  mem_addr = 4'd0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wmask = 4'd0;
  logic [31:0] mem_rdata;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0]  mq[$];
  logic        m_ovr = 1'b0;
  logic        m_ien = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] rd_obs;

  uart_rx_fifo_mmio #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status(input int n);
    logic [31:0] w;
    w = 32'(n) << 8;
    w[0] = (n > 0);
    w[1] = (n == DEPTH);
    w[2] = m_ovr;
    w[3] = m_ien;
    return w;
  endfunction

  // One bus/receiver cycle: predict, drive, clock, compare.
  task automatic cyc(input logic s, input logic r, input logic [3:0] a,
                     input logic [3:0] wm, input logic [31:0] wd,
                     input logic dv, input logic [7:0] b, input logic rst);
    int n;
    logic pop_ok, drop, ctl, fl, clr;
    logic [31:0] m_irq;
    n = mq.size();
    drop = 1'b0;
    if (rst) begin
      mq.delete();
      m_ovr = 1'b0;
      m_ien = 1'b0;
      m_rdata = 32'd0;
    end else begin
      if (s && r) begin
        case (a[3:2])
          2'd0:    m_rdata = (n > 0) ? (32'h100 | 32'(mq[0])) : 32'd0;
          2'd1:    m_rdata = m_status(n);
          2'd2:    m_rdata = m_ien ? 32'd4 : 32'd0;
          default: m_rdata = 32'd0;
        endcase
      end
      ctl = s && wm[0] && (a[3:2] == 2'd2);
      fl  = ctl && wd[0];
      clr = ctl && wd[1];
      pop_ok = s && r && (a[3:2] == 2'd0) && (n > 0);
      if (fl) begin
        mq.delete();
      end else begin
        if (pop_ok) void'(mq.pop_front());
        if (dv) begin
          if (n < DEPTH || pop_ok) mq.push_back(b);
          else drop = 1'b1;
        end
      end
      m_ovr = (m_ovr && !clr) || drop;
      if (ctl) m_ien = wd[2];
    end
    m_irq = {31'd0, m_ien && (mq.size() > 0 || m_ovr)};

    @(negedge clk);
    sel = s; mem_rstrb = r; mem_addr = a; mem_wmask = wm; mem_wdata = wd;
    rx_dv = dv; rx_byte = b; reset = rst;
    @(posedge clk);
    #1;
    sel = 1'b0; mem_rstrb = 1'b0; mem_wmask = 4'd0; rx_dv = 1'b0; reset = 1'b0;
    rd_obs = mem_rdata;
    chk("model_rdata", mem_rdata, m_rdata);
    chk("model_irq", {31'd0, irq}, m_irq);
  endtask

  task automatic push(input logic [7:0] b);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b1, b, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b1, 1'b1, a, 4'h0, 32'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    cyc(1'b1, 1'b0, a, 4'hF, v, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic s, r, dv, rst;
    logic [3:0] a, wm;
    logic [31:0] wd;

    // Reset state.
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0, 8'd0, 1'b1);
    chk("reset_rdata", rd_obs, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd(4'h4); chk("reset_status", rd_obs, 32'h0000_0000);
    rd(4'h0); chk("reset_data", rd_obs, 32'h0000_0000);
    wr(4'hC, 32'h0000_0007);
    rd(4'h8); chk("rsvd_write_ignored", rd_obs, 32'h0000_0000);
    rd(4'hC); chk("rsvd_read", rd_obs, 32'h0000_0000);

    // Three bytes in, three out, then empty.
    push(8'h41); push(8'h42); push(8'h43);
    rd(4'h0); chk("data_41", rd_obs, 32'h0000_0141);
    rd(4'h0); chk("data_42", rd_obs, 32'h0000_0142);
    rd(4'h4); chk("status_cnt1", rd_obs, 32'h0000_0101);
    rd(4'h0); chk("data_43", rd_obs, 32'h0000_0143);
    rd(4'h0); chk("data_empty", rd_obs, 32'h0000_0000);

    // Overfill by one: the 17th byte is lost.
    for (int i = 0; i < 17; i++) push(8'(i));
    rd(4'h4); chk("status_full_ovr", rd_obs, 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      rd(4'h0); chk("data_fill", rd_obs, 32'h100 | 32'(i));
    end
    rd(4'h0); chk("data_after_drain", rd_obs, 32'h0000_0000);

    // Full with simultaneous push and pop.
    wr(4'h8, 32'h0000_0002);
    rd(4'h4); chk("ovr_cleared", rd_obs, 32'h0000_0000);
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    cyc(1'b1, 1'b1, 4'h0, 4'h0, 32'd0, 1'b1, 8'hAA, 1'b0);
    chk("full_pushpop_head", rd_obs, 32'h0000_0120);
    rd(4'h4); chk("full_pushpop_status", rd_obs, 32'h0000_1003);
    for (int i = 1; i < 16; i++) rd(4'h0);
    chk("before_last", rd_obs, 32'h0000_012F);
    rd(4'h0); chk("last_is_aa", rd_obs, 32'h0000_01AA);

    // Interrupt behaviour.
    wr(4'h8, 32'h0000_0004);
    chk("irq_en_empty", {31'd0, irq}, 32'd0);
    rd(4'h8); chk("ctrl_read", rd_obs, 32'h0000_0004);
    push(8'h55);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd(4'h0); chk("data_55", rd_obs, 32'h0000_0155);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
    chk("irq_ovr", {31'd0, irq}, 32'd1);
    wr(4'h8, 32'h0000_0006);
    rd(4'h4); chk("clr_ovr_keep_en", rd_obs, 32'h0000_100B);
    wr(4'h8, 32'h0000_0005);
    chk("irq_after_flush", {31'd0, irq}, 32'd0);
    rd(4'h4); chk("status_after_flush", rd_obs, 32'h0000_0008);

    // Flush in the same cycle as a push.
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    cyc(1'b1, 1'b0, 4'h8, 4'h1, 32'h0000_0001, 1'b1, 8'h77, 1'b0);
    rd(4'h4); chk("flush_push_status", rd_obs, 32'h0000_0000);
    rd(4'h0); chk("flush_push_data", rd_obs, 32'h0000_0000);

    // Reset with data present; the rx_dv in the reset cycle is ignored.
    push(8'h11); push(8'h12); push(8'h13);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b1, 8'h99, 1'b1);
    rd(4'h4); chk("status_after_reset", rd_obs, 32'h0000_0000);

    // Randomized traffic: a filling phase then a draining phase.
    for (int i = 0; i < 800; i++) begin
      s   = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 1) == 1;
      a   = 4'($urandom);
      wm  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      wd  = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 15) == 0) wd[0] = 1'b1;
      dv  = (i < 400) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc(s, r, a, wm, wd, dv, 8'($urandom), rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
